fill_list_queue: RTL and testbench
==================================

# fill_list_queue

Parametrised ordered list of outstanding cache fill tags for the cache miss path. It is the next generation of the fixed 2**tag_bits fill list: depth is decoupled from tag width, and it adds overflow, duplicate and miss detection. It also adds cancellation of not-yet-issued entries and status outputs. Miss logic appends tags, the fill engine reads them out in order, and fill completion deletes them by tag.

## Interface
- TAG_BITS, 3: width of a fill tag.
- DEPTH, 8: number of list slots, 2..64, need not be a power of two.
- CNT_BITS, clog2(DEPTH+1): width of count and issue pointer; derived, not overridden.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  when 0, all state holds and pulse outputs are 0.
- add  in  1  append add_tag.
- add_tag  in  TAG_BITS  tag to append.
- del  in  1  remove entry matching del_tag.
- del_tag  in  TAG_BITS  tag to remove.
- read  in  1  issue next pending entry.
- valid_out  out  1  registered; tag_out is valid this cycle.
- tag_out  out  TAG_BITS  registered issued tag, 0 when valid_out=0.
- count  out  CNT_BITS  registered number of valid entries.
- pending  out  CNT_BITS  count minus issue pointer (entries not yet issued).
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- err_overflow  out  1  registered one-cycle pulse: add dropped, list full.
- err_dup  out  1  registered pulse: add dropped, tag already present.
- err_miss  out  1  registered pulse: del matched no entry.

## Operation
- Storage: slots 0..count-1 hold tags in insertion order. Slots at count and above are invalid and zero.
- Issue pointer ip: slots [0,ip) are issued, [ip,count) are pending. Invariant 0<=ip<=count.
- Delete hit: the lowest valid slot h with tag==del_tag. Slots h+1..count-1 shift down by one and the top slot clears. d=1 on a hit, else d=0. A miss sets err_miss and changes nothing.
- Read: r=1 when read and ip<count. valid_out=1 and tag_out=tags[ip], both taken from the pre-update state. When ip==count, read is ignored, valid_out=0 and no error is raised.
- Pointer update: ip1 = ip + r. ip_next = ip1 - 1 if d and h<ip1, else ip1. Deleting a pending entry (h>=ip1) cancels it and ip is unchanged.
- Add accepted (a=1) if both hold:
  - the tag is not present in any valid slot other than h; else err_dup.
  - (count - d) < DEPTH; else err_overflow. A full list plus a delete hit in the same cycle accepts the add.
- Accepted add writes slot count-d, after compaction.
- A duplicate that is also full reports err_dup only.
- count_next = count + a - d.
- Same-cycle add and del of the same present tag: the delete removes the old entry and the add appends it again at the tail as pending.
- enable=0: no state change. valid_out, tag_out and err_* register to 0.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - all slots 0, ip=0, count=0;
  - valid_out=0, tag_out=0, all err_*=0;
  - hence empty=1, full=0, pending=0.
- All updates take effect on the rising clk after the inputs are sampled; latency is 1 cycle.
- valid_out, tag_out and err_* are single-cycle pulses registered with the state update.
- count, pending, full and empty are derived combinationally from registered count and ip. They reflect the post-update state in the cycle after the event.
- No combinational path from inputs to outputs.
- Reset mid-operation discards all entries; no output pulses follow reset release.

## Test plan
- Reset, then add tags 5,2,7 on consecutive cycles -> count=3, pending=3, empty=0. Then read x3 -> tag_out 5,2,7 with valid_out=1 each cycle, pending=0. A 4th read -> valid_out=0.
- DEPTH=8: fill 8 tags -> full=1. Add 9th -> err_overflow=1, count=8. Add 1 plus del of a present tag in the same cycle -> accepted, count=8, new tag in slot 7.
- List 1,2,3,4, ip=2: del 1 -> ip=1, count=3, next read returns 3. Del 4 (pending) -> ip unchanged, pending=1 → 0 after the read.
- Read and del of tag at slot ip in the same cycle (list 6,3, ip=0, del 6 + read) -> tag_out=6, ip=0, count=1, next read returns 3.
- Add an already present tag -> err_dup=1, count unchanged. Del an absent tag -> err_miss=1, state unchanged. Add and del the same present tag -> count unchanged, tag moved to the tail as pending.
- enable=0 with add/del/read asserted -> no change, valid_out=0. Assert reset mid-sequence with count=5 -> count=0, valid_out=0 immediately.

Source files
------------

// File: rtl/fill_list_queue_if.sv
// Request/status bundle between the miss path and the fill list queue.
// The master side drives the requests. The slave side is the queue.
interface fill_list_queue_if #(
  parameter int unsigned TAG_BITS = 3,
  parameter int unsigned DEPTH    = 8
);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic                enable;
  logic                add;
  logic [TAG_BITS-1:0] add_tag;
  logic                del;
  logic [TAG_BITS-1:0] del_tag;
  logic                read;
  logic                valid_out;
  logic [TAG_BITS-1:0] tag_out;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] pending;
  logic                full;
  logic                empty;
  logic                err_overflow;
  logic                err_dup;
  logic                err_miss;

  modport master (
    output enable, add, add_tag, del, del_tag, read,
    input  valid_out, tag_out, count, pending, full, empty,
           err_overflow, err_dup, err_miss
  );

  modport slave (
    input  enable, add, add_tag, del, del_tag, read,
    output valid_out, tag_out, count, pending, full, empty,
           err_overflow, err_dup, err_miss
  );
endinterface

// File: rtl/fill_list_queue.sv
// Ordered list of outstanding fill tags. Tags are appended at the tail and issued in order.
// A delete by tag compacts the list and can cancel a pending entry.
module fill_list_queue #(
  parameter int unsigned TAG_BITS = 3,
  parameter int unsigned DEPTH    = 8
) (
  input logic              clk,
  input logic              reset,
  fill_list_queue_if.slave bus_io
);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  typedef logic [CNT_BITS-1:0] cnt_t;

  logic [DEPTH-1:0][TAG_BITS-1:0] tags_q, tags_d;
  cnt_t                           count_q, count_d;
  cnt_t                           ip_q, ip_d;
  logic                           valid_q, valid_d;
  logic [TAG_BITS-1:0]            tag_out_q, tag_out_d;
  logic                           err_ov_q, err_ov_d;
  logic                           err_dup_q, err_dup_d;
  logic                           err_miss_q, err_miss_d;

  logic                hit, d, dup, room, r, a;
  cnt_t                h, wr_idx, ip1;
  logic [TAG_BITS-1:0] rd_tag;

  // Lowest valid slot holding del_tag. The downward scan leaves the lowest match in h.
  always_comb begin
    hit = 1'b0;
    h   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (cnt_t'(i) < count_q && tags_q[i] == bus_io.del_tag) begin
        hit = 1'b1;
        h   = cnt_t'(i);
      end
    end
  end

  assign d = bus_io.del && hit;

  // The slot being deleted this cycle does not count as a duplicate.
  always_comb begin
    dup    = 1'b0;
    rd_tag = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (cnt_t'(i) < count_q && tags_q[i] == bus_io.add_tag && !(d && cnt_t'(i) == h)) begin
        dup = 1'b1;
      end
      if (cnt_t'(i) == ip_q) begin
        rd_tag = tags_q[i];
      end
    end
  end

  assign room   = (count_q - cnt_t'(d)) < cnt_t'(DEPTH);
  assign r      = bus_io.read && (ip_q < count_q);
  assign a      = bus_io.add && !dup && room;
  assign wr_idx = count_q - cnt_t'(d);
  assign ip1    = ip_q + cnt_t'(r);

  always_comb begin
    ip_d    = (d && h < ip1) ? ip1 - cnt_t'(1) : ip1;
    count_d = count_q + cnt_t'(a) - cnt_t'(d);
    tags_d  = tags_q;
    // Slots above count are zero, so the shift also clears the old top slot.
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (d && cnt_t'(i) >= h) begin
        tags_d[i] = tags_q[i+1];
      end
    end
    if (d) begin
      tags_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (a && cnt_t'(i) == wr_idx) begin
        tags_d[i] = bus_io.add_tag;
      end
    end
  end

  always_comb begin
    valid_d    = bus_io.enable && r;
    tag_out_d  = (bus_io.enable && r) ? rd_tag : '0;
    err_ov_d   = bus_io.enable && bus_io.add && !dup && !room;
    err_dup_d  = bus_io.enable && bus_io.add && dup;
    err_miss_d = bus_io.enable && bus_io.del && !hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags_q  <= '0;
      count_q <= '0;
      ip_q    <= '0;
    end else if (bus_io.enable) begin
      tags_q  <= tags_d;
      count_q <= count_d;
      ip_q    <= ip_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      tag_out_q  <= '0;
      err_ov_q   <= 1'b0;
      err_dup_q  <= 1'b0;
      err_miss_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      tag_out_q  <= tag_out_d;
      err_ov_q   <= err_ov_d;
      err_dup_q  <= err_dup_d;
      err_miss_q <= err_miss_d;
    end
  end

  assign bus_io.valid_out    = valid_q;
  assign bus_io.tag_out      = tag_out_q;
  assign bus_io.count        = count_q;
  assign bus_io.pending      = count_q - ip_q;
  assign bus_io.full         = (count_q == cnt_t'(DEPTH));
  assign bus_io.empty        = (count_q == '0);
  assign bus_io.err_overflow = err_ov_q;
  assign bus_io.err_dup      = err_dup_q;
  assign bus_io.err_miss     = err_miss_q;
endmodule

// File: tb/tb_fill_list_queue.sv
// Directed table-driven bench for fill_list_queue (TAG_BITS=4, DEPTH=8).
module tb_fill_list_queue;
  localparam int unsigned TB = 4;
  localparam int unsigned DP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fill_list_queue_if #(.TAG_BITS(TB), .DEPTH(DP)) bus ();

  fill_list_queue #(.TAG_BITS(TB), .DEPTH(DP)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       add;
    logic [3:0] at;
    logic       del;
    logic [3:0] dt;
    logic       rd;
    logic       vo;
    logic [3:0] to;
    logic [3:0] cnt;
    logic [3:0] pend;
    logic       eo;
    logic       ed;
    logic       em;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic rst, en, add, input logic [3:0] at, input logic del,
                              input logic [3:0] dt, input logic rd, vo, input logic [3:0] to,
                              input logic [3:0] cnt, pend, input logic eo, ed, em);
    return '{rst, en, add, at, del, dt, rd, vo, to, cnt, pend, eo, ed, em};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, add, input logic [3:0] at, input logic del,
                       input logic [3:0] dt, input logic rd);
    bus.enable  = en;
    bus.add     = add;
    bus.add_tag = at;
    bus.del     = del;
    bus.del_tag = dt;
    bus.read    = rd;
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check("valid_out", idx, 32'(bus.valid_out), 32'(v.vo));
    check("tag_out", idx, 32'(bus.tag_out), 32'(v.to));
    check("count", idx, 32'(bus.count), 32'(v.cnt));
    check("pending", idx, 32'(bus.pending), 32'(v.pend));
    check("full", idx, 32'(bus.full), 32'(v.cnt == 4'd8));
    check("empty", idx, 32'(bus.empty), 32'(v.cnt == 4'd0));
    check("err_overflow", idx, 32'(bus.err_overflow), 32'(v.eo));
    check("err_dup", idx, 32'(bus.err_dup), 32'(v.ed));
    check("err_miss", idx, 32'(bus.err_miss), 32'(v.em));
  endtask

  initial begin
    // rst en add at del dt rd | vo to cnt pend eo ed em
    vecs.push_back(mk(0,1,1,5,0,0,0, 0,0,1,1,0,0,0));
    vecs.push_back(mk(0,1,1,2,0,0,0, 0,0,2,2,0,0,0));
    vecs.push_back(mk(0,1,1,7,0,0,0, 0,0,3,3,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,5,3,2,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,2,3,1,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,7,3,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 0,0,3,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0, 0,0,4,1,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0, 0,0,5,2,0,0,0));
    vecs.push_back(mk(0,1,1,3,0,0,0, 0,0,6,3,0,0,0));
    vecs.push_back(mk(0,1,1,4,0,0,0, 0,0,7,4,0,0,0));
    vecs.push_back(mk(0,1,1,6,0,0,0, 0,0,8,5,0,0,0));
    vecs.push_back(mk(0,1,1,9,0,0,0, 0,0,8,5,1,0,0));   // overflow
    vecs.push_back(mk(0,1,1,10,1,5,0, 0,0,8,6,0,0,0));  // full + del hit accepts add
    vecs.push_back(mk(0,1,0,0,1,9,0, 0,0,8,6,0,0,1));   // miss
    vecs.push_back(mk(0,1,1,7,0,0,0, 0,0,8,6,0,1,0));   // dup while full
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,0,8,5,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,1,8,4,0,0,0));
    vecs.push_back(mk(0,0,1,11,1,2,1, 0,0,8,4,0,0,0));  // enable low
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,3,8,3,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,4,8,2,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,6,8,1,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,10,8,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,0, 0,0,1,1,0,0,0));
    vecs.push_back(mk(0,1,1,2,0,0,0, 0,0,2,2,0,0,0));
    vecs.push_back(mk(0,1,1,3,0,0,0, 0,0,3,3,0,0,0));
    vecs.push_back(mk(0,1,1,4,0,0,0, 0,0,4,4,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,1,4,3,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,2,4,2,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,1,0, 0,0,3,2,0,0,0));   // del issued entry, ip drops
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,3,3,1,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,4,0, 0,0,2,0,0,0,0));   // cancel pending
    vecs.push_back(mk(0,1,0,0,0,0,1, 0,0,2,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,0,0, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,6,0,0,0, 0,0,1,1,0,0,0));
    vecs.push_back(mk(0,1,1,3,0,0,0, 0,0,2,2,0,0,0));
    vecs.push_back(mk(0,1,0,0,1,6,1, 1,6,1,1,0,0,0));   // read + del same slot
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,3,1,0,0,0,0));
    vecs.push_back(mk(0,1,1,5,0,0,0, 0,0,2,1,0,0,0));
    vecs.push_back(mk(0,1,1,3,1,3,0, 0,0,2,2,0,0,0));   // re-append at tail
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,5,2,1,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,1, 1,3,2,0,0,0,0));

    drive(1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset = ~vecs[k].rst;
      drive(vecs[k].en, vecs[k].add, vecs[k].at, vecs[k].del, vecs[k].dt, vecs[k].rd);
      @(posedge clk);
      #1;
      check_all(k, vecs[k]);
    end

    // Asynchronous reset mid-sequence with five entries and a live read pulse.
    @(negedge clk); reset = 1'b1; drive(1, 1, 1, 0, 0, 0);
    @(negedge clk); drive(1, 1, 2, 0, 0, 0);
    @(negedge clk); drive(1, 1, 4, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("pre_rst_count", 100, 32'(bus.count), 32'd5);
    check("pre_rst_valid", 100, 32'(bus.valid_out), 32'd1);
    check("pre_rst_tag", 100, 32'(bus.tag_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 101, 32'(bus.count), 32'd0);
    check("async_valid", 101, 32'(bus.valid_out), 32'd0);
    check("async_pending", 101, 32'(bus.pending), 32'd0);
    check("async_empty", 101, 32'(bus.empty), 32'd1);
    @(negedge clk); reset = 1'b1; drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("post_rst_valid", 102, 32'(bus.valid_out), 32'd0);
    check("post_rst_count", 102, 32'(bus.count), 32'd0);
    check("post_rst_errs", 102,
          32'({bus.err_overflow, bus.err_dup, bus.err_miss}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
